pipe_ctrl_s: RTL and testbench

//  Central pipeline sequencer for the 5-stage core. Consumes hdu_s stall, EX branch redirect and
//  the MEM-stage data-memory handshake; drives per-stage register enables and flushes. A small FSM

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_ctrl_s_sat_counter.sv | 19 +
 rtl/pipe_ctrl_s.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl_s.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline sequencer.
// State encoding plus default counter width and memory timeout.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipe_ctrl_s_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      q <= '0;
    else if (en && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/pipe_ctrl_s.sv
// Central pipeline sequencer: stage enables, flushes, dmem wait FSM,
// timeout trap and saturating stall/flush perf counters.
module pipe_ctrl_s
  import pipe_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hdu_stall,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  ctrl_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          freeze, served;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    freeze       = 1'b0;
    served       = 1'b0;
    dmem_req     = 1'b0;
    pc_we        = 1'b1;
    pc_redirect  = 1'b0;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    memwb_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    err          = 1'b0;

    unique case (state_q)
      RUN: begin
        dmem_req = mem_access;
        if (mem_access && !dmem_ack) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          timer_d = TW'(1);
        end else begin
          served = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          served  = 1'b1;
          state_d = RUN;
          timer_d = '0;
        end else begin
          freeze = 1'b1;
          if (timer_q == T_LAST)
            state_d = ERR;
          else
            timer_d = timer_q + TW'(1);
        end
      end
      ERR: begin
        err      = 1'b1;
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_we = 1'b0;
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end

    // A taken branch squashes the younger stalled instruction.
    if (served) begin
      priority case (1'b1)
        ex_branch_taken: begin
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end
        hdu_stall: begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end

    // Reset drops any request at once and leaves the pipe open.
    if (!rst_n) begin
      dmem_req     = 1'b0;
      pc_we        = 1'b1;
      pc_redirect  = 1'b0;
      ifid_we      = 1'b1;
      idex_we      = 1'b1;
      exmem_we     = 1'b1;
      memwb_we     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      err          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (!pc_we),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (pc_redirect),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_s.sv
// Directed self-checking bench for pipe_ctrl_s (CNT_W=4, MEM_TIMEOUT=4).
// Control outputs are packed into one vector for compact comparison.
module tb_pipe_ctrl_s;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hdu_stall, ex_branch_taken, mem_access, dmem_ack;
  logic       dmem_req, pc_we, pc_redirect, ifid_we, idex_we;
  logic       exmem_we, memwb_we, ifid_flush, idex_flush;
  logic       memwb_bubble, err;
  logic [3:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  // {pc_we,redir,ifid_we,idex_we,exmem_we,memwb_we,ifid_fl,idex_fl,bubble,req,err}
  localparam logic [10:0] IDLE   = 11'b1_0_1_1_1_1_0_0_0_0_0;
  localparam logic [10:0] LU     = 11'b0_0_0_1_1_1_0_1_0_0_0;
  localparam logic [10:0] BR     = 11'b1_1_1_1_1_1_1_1_0_0_0;
  localparam logic [10:0] FRZ    = 11'b0_0_0_0_0_1_0_0_1_1_0;
  localparam logic [10:0] ACK    = 11'b1_0_1_1_1_1_0_0_0_1_0;
  localparam logic [10:0] ACK_BR = 11'b1_1_1_1_1_1_1_1_0_1_0;
  localparam logic [10:0] ERRV   = 11'b0_0_0_0_0_0_0_0_0_0_1;

  logic [10:0] ctl;
  assign ctl = {pc_we, pc_redirect, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_flush, idex_flush, memwb_bubble, dmem_req, err};

  pipe_ctrl_s #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hdu_stall       (hdu_stall),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .dmem_ack        (dmem_ack),
    .dmem_req        (dmem_req),
    .pc_we           (pc_we),
    .pc_redirect     (pc_redirect),
    .ifid_we         (ifid_we),
    .idex_we         (idex_we),
    .exmem_we        (exmem_we),
    .memwb_we        (memwb_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .err             (err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic b,
                       input logic m, input logic a);
    hdu_stall       = h;
    ex_branch_taken = b;
    mem_access      = m;
    dmem_ack        = a;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(IDLE));
    drive(0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: idle
    repeat (5) tick();
    chk("idle_ctl", 32'(ctl), 32'(IDLE));
    chk("idle_stall", 32'(stall_cnt), 32'd0);
    chk("idle_flush", 32'(flush_cnt), 32'd0);

    // 2: load-use
    drive(1, 0, 0, 0);
    chk("lu_ctl", 32'(ctl), 32'(LU));
    tick();
    drive(0, 0, 0, 0);
    chk("lu_stall", 32'(stall_cnt), 32'd1);

    // 3: branch beats load-use
    drive(1, 1, 0, 0);
    chk("br_ctl", 32'(ctl), 32'(BR));
    tick();
    drive(0, 0, 0, 0);
    chk("br_flush", 32'(flush_cnt), 32'd1);
    chk("br_stall", 32'(stall_cnt), 32'd1);

    // 4: access acked on 4th cycle
    drive(0, 0, 1, 0);
    chk("mem_c1", 32'(ctl), 32'(FRZ));
    tick();
    chk("mem_c2", 32'(ctl), 32'(FRZ));
    tick();
    chk("mem_c3", 32'(ctl), 32'(FRZ));
    tick();
    drive(0, 0, 1, 1);
    chk("mem_ack", 32'(ctl), 32'(ACK));
    tick();
    drive(0, 0, 0, 0);
    chk("mem_back_run", 32'(ctl), 32'(IDLE));
    chk("mem_stall", 32'(stall_cnt), 32'd4);

    // stray ack, then same-cycle ack
    drive(0, 0, 0, 1);
    chk("stray_ack", 32'(ctl), 32'(IDLE));
    drive(0, 0, 1, 1);
    chk("fast_ack", 32'(ctl), 32'(ACK));
    tick();

    // branch held during wait is applied on the ack cycle
    drive(0, 1, 1, 0);
    chk("wbr_c1", 32'(ctl), 32'(FRZ));
    tick();
    chk("wbr_c2", 32'(ctl), 32'(FRZ));
    chk("wbr_noflush", 32'(flush_cnt), 32'd1);
    tick();
    drive(0, 1, 1, 1);
    chk("wbr_ack", 32'(ctl), 32'(ACK_BR));
    tick();
    drive(0, 0, 0, 0);
    chk("wbr_flush", 32'(flush_cnt), 32'd2);
    chk("wbr_stall", 32'(stall_cnt), 32'd6);

    // 5: timeout into ERR
    drive(0, 0, 1, 0);
    repeat (3) begin
      chk("to_wait", 32'(ctl), 32'(FRZ));
      tick();
    end
    chk("to_last", 32'(ctl), 32'(FRZ));
    tick();
    drive(0, 0, 0, 0);
    chk("err_ctl", 32'(ctl), 32'(ERRV));
    chk("err_stall", 32'(stall_cnt), 32'd10);
    tick();
    drive(1, 1, 1, 1);
    chk("err_sticky", 32'(ctl), 32'(ERRV));
    tick();
    drive(0, 0, 0, 0);
    chk("err_stall2", 32'(stall_cnt), 32'd12);
    chk("err_noflush", 32'(flush_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(IDLE));
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst", 32'(ctl), 32'(IDLE));

    // 6: saturation
    drive(1, 0, 0, 0);
    repeat (20) tick();
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    drive(0, 1, 0, 0);
    repeat (20) tick();
    chk("sat_flush", 32'(flush_cnt), 32'd15);
    chk("sat_stall_hold", 32'(stall_cnt), 32'd15);

    // reset mid-wait drops the request immediately
    drive(0, 0, 1, 0);
    tick();
    tick();
    chk("mw_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mw_rst_req", 32'(dmem_req), 32'd0);
    chk("mw_rst_ctl", 32'(ctl), 32'(IDLE));
    drive(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_idle", 32'(ctl), 32'(IDLE));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
